// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: ID-stage stall decision and mult/div busy tracking for the 5-stage MIPS pipeline.
// Optional HAZARD_STALL_COUNT_EN adds a free-running 32-bit StallCount of stall cycles.
module hazard_detect_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] IDRs,
  input  logic [4:0] IDRt,
  input  logic       IDUsesRt,
  input  logic       IDIsBranch,
  input  logic       IDIsMul,
  input  logic       IDIsDiv,
  input  logic       IDReadsHiLo,
  input  logic       IDFlush,
  input  logic       EXMemRead,
  input  logic       EXRegWrite,
  input  logic [4:0] EXDest,
  input  logic       MEMMemRead,
  input  logic [4:0] MEMDest,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       HazardMuxSelect,
  output logic       MdBusy
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0] StallCount
`endif
);
  logic [CNT_W-1:0] cnt, cntNext;
  logic exMatch, memMatch, loadUse, branchAlu, branchLoad, hiLo, stall, issue;
  always_comb begin
    exMatch = (EXDest != 5'd0) && (EXDest == IDRs || (IDUsesRt && EXDest == IDRt));
    memMatch = (MEMDest != 5'd0) && (MEMDest == IDRs || (IDUsesRt && MEMDest == IDRt));
    loadUse = EXMemRead && exMatch;
    branchAlu = IDIsBranch && EXRegWrite && !EXMemRead && exMatch;
    branchLoad = IDIsBranch && MEMMemRead && memMatch;
    hiLo = MdBusy && (IDReadsHiLo || IDIsMul || IDIsDiv);
    stall = !Reset && !IDFlush && (loadUse || branchAlu || branchLoad || hiLo);
  end
  always_ff @(posedge Clk) cnt <= Reset ? '0 : cntNext;
  // A held mult/div only starts counting on the cycle it is actually released
  always_comb begin
    issue = (IDIsMul || IDIsDiv) && !stall && !IDFlush;
    cntNext = issue ? (IDIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES))
                    : (cnt != '0 ? cnt - CNT_W'(1) : cnt);
  end
  always_comb begin
    HazardMuxSelect = stall;
    PCWrite = !stall;
    IFIDWrite = !stall;
    MdBusy = cnt != '0;
  end
`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge Clk) StallCount <= Reset ? '0 : StallCount + 32'(stall);
`endif
endmodule
